// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART TX line between NUM_REQ byte-stream requesters.
// Round-robin grant at line granularity. The owner keeps the line until LF, MAX_LINE
// bytes, or LOCK_TIMEOUT idle cycles. The serializer sends 8N1 frames, LSB first.
// Optional feature: define UART_TX_ARBITER_PARITY_EN to add an even-parity bit.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned MAX_LINE     = 254,
  parameter int unsigned LOCK_TIMEOUT = 4096
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*8-1:0]       req_data_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic                       tx_o,
  output logic                       busy_o,
  output logic [$clog2(NUM_REQ)-1:0] owner_o,
  output logic                       locked_o
);

  localparam int unsigned IdxW  = $clog2(NUM_REQ);
  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam int unsigned ToW   = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [BaudW-1:0] BaudLast  = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [ToW-1:0]   ToLimit   = ToW'(LOCK_TIMEOUT);
  localparam logic [7:0]       LineLimit = 8'(MAX_LINE);

  typedef enum logic {ArbIdle, ArbLocked} arb_state_e;

`ifdef UART_TX_ARBITER_PARITY_EN
  typedef enum logic [2:0] {SIdle, SStart, SData, SParity, SStop} ser_state_e;
`else
  typedef enum logic [2:0] {SIdle, SStart, SData, SStop} ser_state_e;
`endif

  arb_state_e        r_arb_state;
  logic [IdxW-1:0]   r_owner;
  logic [7:0]        r_line_cnt;
  logic [ToW-1:0]    r_to_cnt;
  ser_state_e        r_ser_state;
  logic [BaudW-1:0]  r_baud_cnt;
  logic [2:0]        r_bit_idx;
  logic [7:0]        r_shift;
  logic              r_tx;
`ifdef UART_TX_ARBITER_PARITY_EN
  logic              r_parity;
`endif

  logic              w_locked;
  logic              w_ser_idle;
  logic              w_to_hit;
  logic              w_owner_valid;
  logic [7:0]        w_owner_data;
  logic              w_ready_own;
  logic              w_accept;
  logic [7:0]        w_line_next;
  logic              w_grant_found;
  logic [IdxW-1:0]   w_grant_idx;

  assign w_locked    = (r_arb_state == ArbLocked);
  assign w_ser_idle  = (r_ser_state == SIdle);
  assign w_to_hit    = (r_to_cnt == ToLimit);
  // A timeout pending this cycle blocks the accept so the release wins.
  assign w_ready_own = w_locked & w_ser_idle & ~w_to_hit;
  assign w_accept    = w_ready_own & w_owner_valid;
  assign w_line_next = r_line_cnt + 8'd1;

  // Select the owner's valid/data and fan the ready out to the owner only.
  always_comb begin
    w_owner_valid = 1'b0;
    w_owner_data  = 8'h00;
    req_ready_o   = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (IdxW'(k) == r_owner) begin
        w_owner_valid  = req_valid_i[k];
        w_owner_data   = req_data_i[k*8 +: 8];
        req_ready_o[k] = w_ready_own;
      end
    end
  end

  // Round-robin search starting one past the last owner; the last owner is checked last.
  always_comb begin : p_grant
    int unsigned     idx;
    logic [IdxW-1:0] idx_c;
    idx           = 0;
    idx_c         = '0;
    w_grant_found = 1'b0;
    w_grant_idx   = r_owner;
    for (int i = 1; i <= int'(NUM_REQ); i++) begin
      idx   = (int'(r_owner) + i) % NUM_REQ;
      idx_c = IdxW'(idx);
      if (!w_grant_found && req_valid_i[idx_c]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = idx_c;
      end
    end
  end

  // Arbiter FSM: grant in idle, hold the line until LF, line limit or timeout.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_arb_state <= ArbIdle;
      r_owner     <= IdxW'(NUM_REQ - 1);
      r_line_cnt  <= '0;
      r_to_cnt    <= '0;
    end else begin
      unique case (r_arb_state)
        ArbIdle: begin
          if (w_grant_found) begin
            r_owner     <= w_grant_idx;
            r_arb_state <= ArbLocked;
            r_line_cnt  <= '0;
            r_to_cnt    <= '0;
          end
        end
        ArbLocked: begin
          if (w_to_hit) begin
            r_arb_state <= ArbIdle;
          end else if (w_accept) begin
            r_line_cnt <= w_line_next;
            r_to_cnt   <= '0;
            if (w_owner_data == 8'h0A || w_line_next == LineLimit) begin
              r_arb_state <= ArbIdle;
            end
          end else if (w_ser_idle && !w_owner_valid) begin
            r_to_cnt <= r_to_cnt + ToW'(1);
          end
        end
        default: r_arb_state <= ArbIdle;
      endcase
    end
  end

  // Serializer FSM: each non-idle state lasts CLKS_PER_BIT cycles; tx is registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ser_state <= SIdle;
      r_baud_cnt  <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_tx        <= 1'b1;
`ifdef UART_TX_ARBITER_PARITY_EN
      r_parity    <= 1'b0;
`endif
    end else begin
      unique case (r_ser_state)
        SIdle: begin
          r_tx <= 1'b1;
          if (w_accept) begin
            r_shift     <= w_owner_data;
            r_ser_state <= SStart;
            r_baud_cnt  <= '0;
            r_tx        <= 1'b0;
`ifdef UART_TX_ARBITER_PARITY_EN
            r_parity    <= ^w_owner_data;
`endif
          end
        end
        SStart: begin
          if (r_baud_cnt == BaudLast) begin
            r_baud_cnt  <= '0;
            r_bit_idx   <= '0;
            r_ser_state <= SData;
            r_tx        <= r_shift[0];
          end else begin
            r_baud_cnt <= r_baud_cnt + BaudW'(1);
          end
        end
        SData: begin
          if (r_baud_cnt == BaudLast) begin
            r_baud_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_ARBITER_PARITY_EN
              r_ser_state <= SParity;
              r_tx        <= r_parity;
`else
              r_ser_state <= SStop;
              r_tx        <= 1'b1;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_shift   <= r_shift >> 1;
              r_tx      <= r_shift[1];
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + BaudW'(1);
          end
        end
`ifdef UART_TX_ARBITER_PARITY_EN
        SParity: begin
          if (r_baud_cnt == BaudLast) begin
            r_baud_cnt  <= '0;
            r_ser_state <= SStop;
            r_tx        <= 1'b1;
          end else begin
            r_baud_cnt <= r_baud_cnt + BaudW'(1);
          end
        end
`endif
        SStop: begin
          r_tx <= 1'b1;
          if (r_baud_cnt == BaudLast) begin
            r_baud_cnt  <= '0;
            r_ser_state <= SIdle;
          end else begin
            r_baud_cnt <= r_baud_cnt + BaudW'(1);
          end
        end
        default: r_ser_state <= SIdle;
      endcase
    end
  end

  assign tx_o     = r_tx;
  assign busy_o   = ~w_ser_idle;
  assign owner_o  = r_owner;
  assign locked_o = w_locked;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: scoreboard of expected bytes checked by a bench UART receiver,
// plus cycle-exact checks of framing, grant latency, round-robin order and forced release.
module tb_uart_tx_arbiter;

  localparam int unsigned NumReq = 4;
  localparam int unsigned Cpb    = 4;
  localparam int unsigned MaxLn  = 3;
  localparam int unsigned LockTo = 16;
`ifdef UART_TX_ARBITER_PARITY_EN
  localparam int FrameBits = 11;
`else
  localparam int FrameBits = 10;
`endif

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic [NumReq-1:0]     req_valid_i;
  logic [NumReq*8-1:0]   req_data_i;
  logic [NumReq-1:0]     req_ready_o;
  logic                  tx_o;
  logic                  busy_o;
  logic [1:0]            owner_o;
  logic                  locked_o;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  bit          rx_en    = 1'b1;
  logic [7:0]  exp_q[$];
  int          grant_log[$];

  uart_tx_arbiter #(
    .NUM_REQ     (NumReq),
    .CLKS_PER_BIT(Cpb),
    .MAX_LINE    (MaxLn),
    .LOCK_TIMEOUT(LockTo)
  ) u_dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .req_valid_i(req_valid_i),
    .req_data_i (req_data_i),
    .req_ready_o(req_ready_o),
    .tx_o       (tx_o),
    .busy_o     (busy_o),
    .owner_o    (owner_o),
    .locked_o   (locked_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] b);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
`ifdef UART_TX_ARBITER_PARITY_EN
    f[9]   = ^b;
`endif
    return f;
  endfunction

  // Present a byte on requester k, wait for the accept; returns at accept cycle + 1.
  task automatic send(input int k, input logic [7:0] b, output int t_acc);
    int waited;
    waited = 0;
    req_data_i[k*8 +: 8] = b;
    req_valid_i[k]       = 1'b1;
    while (!req_ready_o[k] && waited < 2000) begin
      tick();
      waited++;
    end
    if (!req_ready_o[k]) check_eq("ready_timeout", {31'd0, req_ready_o[k]}, 1);
    t_acc = cyc;
    tick();
    req_valid_i[k] = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 5000) begin
      tick();
      w++;
    end
    check_eq("drain", exp_q.size(), 0);
    repeat (2 * Cpb) tick();
  endtask

  task automatic do_reset();
    rst_i       = 1'b1;
    req_valid_i = '0;
    repeat (2) tick();
    grant_log.delete();
    rst_i = 1'b0;
  endtask

  // Bench UART receiver: samples mid-bit and compares against the scoreboard.
  initial begin : p_rx
    logic [7:0] d;
    logic       p;
    d = '0;
    p = 1'b0;
    forever begin
      tick();
      if (rx_en && tx_o === 1'b0) begin
        repeat (Cpb / 2) tick();
        for (int i = 0; i < 8; i++) begin
          repeat (Cpb) tick();
          d[i] = tx_o;
        end
`ifdef UART_TX_ARBITER_PARITY_EN
        repeat (Cpb) tick();
        p = tx_o;
        check_eq("rx_parity", {31'd0, p}, {31'd0, ^d});
`endif
        repeat (Cpb) tick();
        check_eq("rx_stop", {31'd0, tx_o}, 1);
        if (exp_q.size() == 0) check_eq("rx_extra", {24'd0, d}, 32'hFFFF_FFFF);
        else check_eq("rx_byte", {24'd0, d}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // Log owner at each rising edge of locked_o.
  initial begin : p_grant_mon
    logic prev;
    prev = 1'b0;
    forever begin
      tick();
      if (locked_o && !prev) grant_log.push_back(int'(owner_o));
      prev = locked_o;
    end
  end

  initial begin : p_watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
    $fatal(1, "time limit");
  end

  initial begin : p_main
    int          t, c0, tlf, tg, tz, ti, tl, w;
    logic [10:0] f;
    int          rr_exp[8];
    rr_exp = '{0, 1, 2, 3, 0, 1, 2, 3};
    rst_i       = 1'b1;
    req_valid_i = '0;
    req_data_i  = '0;
    do_reset();

    // Reset values
    check_eq("rst_tx", {31'd0, tx_o}, 1);
    check_eq("rst_ready", {28'd0, req_ready_o}, 0);
    check_eq("rst_busy", {31'd0, busy_o}, 0);
    check_eq("rst_owner", {30'd0, owner_o}, NumReq - 1);
    check_eq("rst_locked", {31'd0, locked_o}, 0);

    // Single byte 0x41: cycle-exact frame
    exp_q.push_back(8'h41);
    c0 = cyc;
    send(0, 8'h41, t);
    check_eq("grant_latency", t - c0, 1);
    f = frame_bits(8'h41);
    for (int n = 0; n < FrameBits; n++) begin
      for (int c = 0; c < int'(Cpb); c++) begin
        check_eq($sformatf("frame_bit%0d", n), {31'd0, tx_o}, {31'd0, f[n]});
        if (n == FrameBits - 1 && c == int'(Cpb) - 1) begin
          check_eq("ready_last_stop", {31'd0, req_ready_o[0]}, 0);
          check_eq("busy_last_stop", {31'd0, busy_o}, 1);
        end
        tick();
      end
    end
    check_eq("ready_back", cyc - t, FrameBits * Cpb + 1);
    check_eq("ready_back_val", {31'd0, req_ready_o[0]}, 1);
    check_eq("busy_after", {31'd0, busy_o}, 0);
    drain();

    // Line locking, then timeout release of req1
    do_reset();
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h42);
    exp_q.push_back(8'h0A);
    exp_q.push_back(8'h5A);
    tlf = 0;
    tg  = 0;
    tz  = 0;
    fork
      begin
        int ta;
        send(0, 8'h41, ta);
        send(0, 8'h42, ta);
        send(0, 8'h0A, tlf);
      end
      begin
        int wb;
        wb = 0;
        req_data_i[15:8] = 8'h5A;
        req_valid_i[1]   = 1'b1;
        while (!(locked_o && owner_o == 2'd1) && wb < 2000) begin
          tick();
          wb++;
        end
        tg = cyc;
        send(1, 8'h5A, tz);
      end
    join
    check_eq("lock_grant_delay", tg - tlf, 2);
    w = 0;
    while (busy_o && w < 500) begin
      tick();
      w++;
    end
    check_eq("idle_wait", {31'd0, busy_o}, 0);
    ti = cyc;
    w  = 0;
    while (locked_o && w < 500) begin
      tick();
      w++;
    end
    tl = cyc;
    check_eq("timeout_release", tl - ti, LockTo + 1);
    check_eq("owner_after_to", {30'd0, owner_o}, 1);
    drain();

    // Round-robin with single LF lines
    do_reset();
    repeat (8) exp_q.push_back(8'h0A);
    fork
      begin int a; send(0, 8'h0A, a); send(0, 8'h0A, a); end
      begin int a; send(1, 8'h0A, a); send(1, 8'h0A, a); end
      begin int a; send(2, 8'h0A, a); send(2, 8'h0A, a); end
      begin int a; send(3, 8'h0A, a); send(3, 8'h0A, a); end
    join
    drain();
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("rr_grant%0d", i), (i < grant_log.size()) ? grant_log[i] : -1, rr_exp[i]);
    end

    // Line-length release without LF
    do_reset();
    exp_q.push_back(8'h31);
    exp_q.push_back(8'h32);
    exp_q.push_back(8'h33);
    send(2, 8'h31, t);
    check_eq("ml_owner", {30'd0, owner_o}, 2);
    send(2, 8'h32, t);
    check_eq("ml_locked2", {31'd0, locked_o}, 1);
    send(2, 8'h33, t);
    check_eq("ml_locked3", {31'd0, locked_o}, 0);
    check_eq("ml_ready3", {28'd0, req_ready_o}, 0);
    drain();

`ifdef UART_TX_ARBITER_PARITY_EN
    // Parity bit of 0x07 is 1
    do_reset();
    exp_q.push_back(8'h07);
    send(1, 8'h07, t);
    repeat (9 * Cpb + 1) tick();
    check_eq("parity_bit", {31'd0, tx_o}, 1);
    drain();
`endif

    // Reset mid-frame during data bit 3
    do_reset();
    rx_en = 1'b0;
    send(3, 8'h55, t);
    repeat (17) tick();
    check_eq("mid_bit3", {31'd0, tx_o}, 0);
    rst_i = 1'b1;
    tick();
    check_eq("mr_tx", {31'd0, tx_o}, 1);
    check_eq("mr_ready", {28'd0, req_ready_o}, 0);
    check_eq("mr_busy", {31'd0, busy_o}, 0);
    check_eq("mr_owner", {30'd0, owner_o}, NumReq - 1);
    check_eq("mr_locked", {31'd0, locked_o}, 0);
    rst_i            = 1'b0;
    req_data_i[7:0]  = 8'h0A;
    req_data_i[23:16] = 8'h0A;
    req_valid_i[0]   = 1'b1;
    req_valid_i[2]   = 1'b1;
    tick();
    check_eq("mr_next_locked", {31'd0, locked_o}, 1);
    check_eq("mr_next_owner", {30'd0, owner_o}, 0);
    req_valid_i = '0;
    tick();

    check_eq("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
